// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 hex keypad scanner.
//   state_e        - scanner FSM states
//   NUM_COLS/ROWS  - keypad geometry
//   KEY_MAP        - hex code per key, indexed {row, col}
//   lowest_low_row - index of the lowest-numbered active-low row
package keypad_pkg;

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned COL_W    = $clog2(NUM_COLS);
  localparam int unsigned ROW_W    = $clog2(NUM_ROWS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_e;

  // Row-major key legend; entry {row, col} gives the hex code of that key.
  localparam logic [0:NUM_ROWS*NUM_COLS-1][3:0] KEY_MAP = {
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  // Lowest-index low row; only meaningful when at least one row is low.
  function automatic logic [ROW_W-1:0] lowest_low_row(input logic [NUM_ROWS-1:0] rows_n);
    logic [ROW_W-1:0] idx;
    idx = ROW_W'(NUM_ROWS - 1);
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows_n[i]) idx = ROW_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous level inputs.
//   clk   - destination clock
//   rst_n - async active-low reset; flops reset to all-ones (idle-high lines)
//   d_i   - asynchronous input bus
//   q_o   - synchronized output, two cycles of latency
module sync_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: column-scanning reader for a 4x4 hex keypad.
//   clkin     - system clock
//   greset_n  - async active-low reset
//   row_n     - keypad rows, active-low, asynchronous
//   col_n     - column drive, exactly one bit low (registered)
//   key       - hex code of the last accepted key
//   key_valid - one-cycle strobe when a press is accepted
//   key_held  - high from press acceptance until release acceptance
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES   = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
  input  logic                clkin,
  input  logic                greset_n,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic [3:0]          key,
  output logic                key_valid,
  output logic                key_held
);

  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES);
  localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [DB_W-1:0]     DB_MAX     = DB_W'(DEBOUNCE_CYCLES - 1);

  // Reject parameter values that cannot cover synchronizer latency or debounce.
  if (SETTLE_CYCLES < 3) begin : g_settle_chk
    $error("keypad_scan: SETTLE_CYCLES must be at least 3");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_db_chk
    $error("keypad_scan: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [NUM_ROWS-1:0] rs;

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [NUM_COLS-1:0] col_n_q, col_n_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [DB_W-1:0]     db_q, db_d;
  logic [ROW_W-1:0]    cand_row_q, cand_row_d;
  logic [3:0]          key_q, key_d;
  logic                key_valid_q, key_valid_d;
  logic                key_held_q, key_held_d;

  // Rows are asynchronous to clkin; every FSM decision uses rs.
  sync_2ff #(
    .WIDTH (NUM_ROWS)
  ) u_row_sync (
    .clk   (clkin),
    .rst_n (greset_n),
    .d_i   (row_n),
    .q_o   (rs)
  );

  // State and output registers.
  always_ff @(posedge clkin or negedge greset_n) begin
    if (!greset_n) begin
      state_q     <= SCAN;
      col_q       <= '0;
      col_n_q     <= ~NUM_COLS'(1);
      settle_q    <= '0;
      db_q        <= '0;
      cand_row_q  <= '0;
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      col_n_q     <= col_n_d;
      settle_q    <= settle_d;
      db_q        <= db_d;
      cand_row_q  <= cand_row_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    settle_d    = settle_q;
    db_d        = db_q;
    cand_row_d  = cand_row_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    unique case (state_q)
      SCAN: begin
        if (settle_q == SETTLE_MAX) begin
          settle_d = '0;
          if (&rs) begin
            col_d = col_q + COL_W'(1);
          end else begin
            cand_row_d = lowest_low_row(rs);
            db_d       = '0;
            state_d    = PRESS_DB;
          end
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end

      PRESS_DB: begin
        if (rs[cand_row_q]) begin
          // Bounce: rescan the same column from a fresh settle window.
          state_d  = SCAN;
          settle_d = '0;
          db_d     = '0;
        end else if (db_q == DB_MAX) begin
          state_d     = HELD;
          db_d        = '0;
          key_d       = KEY_MAP[{cand_row_q, col_q}];
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end

      HELD: begin
        if (rs[cand_row_q]) begin
          state_d = REL_DB;
          db_d    = '0;
        end
      end

      REL_DB: begin
        if (!rs[cand_row_q]) begin
          // Release bounce: back to HELD, no new strobe.
          state_d = HELD;
          db_d    = '0;
        end else if (db_q == DB_MAX) begin
          state_d    = SCAN;
          db_d       = '0;
          settle_d   = '0;
          key_held_d = 1'b0;
          col_d      = col_q + COL_W'(1);
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase

    col_n_d = ~(NUM_COLS'(1) << col_d);
  end

  assign col_n     = col_n_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed, self-checking bench for keypad_scan
// (SETTLE_CYCLES=4, DEBOUNCE_CYCLES=8) with a column-gated keypad model.
module tb_keypad_scan;

  logic       clk;
  logic       greset_n;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;   // bit r*4+c = key at row r, column c is closed

  int tests;
  int fails;
  int cyc;
  int pulses;
  int last_pulse;

  keypad_scan #(
    .SETTLE_CYCLES   (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clkin     (clk),
    .greset_n  (greset_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A closed key pulls its row low only while its column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[4'(r * 4 + c)] && !col_n[2'(c)]) row_n[2'(r)] = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (key_valid) begin
        pulses++;
        last_pulse = cyc;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Stop on the edge at which col_n switches to target (bounded).
  task automatic wait_col(input logic [3:0] target);
    int n;
    n = 0;
    while (col_n == target && n < 100) begin step(1); n++; end
    while (col_n != target && n < 100) begin step(1); n++; end
    check("wait_col", 32'(col_n), 32'(target));
  endtask

  typedef struct {
    logic [15:0] mask;
    logic [3:0]  exp_key;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [3:0] exp_cn;
    int p0;
    int p1;
    int c0;

    tests = 0; fails = 0; cyc = 0; pulses = 0; last_pulse = 0;
    pressed  = 16'h0;
    greset_n = 1'b0;

    vecs[0] = '{16'h0040, 4'h6};  // r1 c2
    vecs[1] = '{16'h1000, 4'h0};  // r3 c0
    vecs[2] = '{16'h0008, 4'hA};  // r0 c3
    vecs[3] = '{16'h8000, 4'hD};  // r3 c3
    vecs[4] = '{16'h0400, 4'h9};  // r2 c2
    vecs[5] = '{16'h4000, 4'hE};  // r3 c2

    // Reset values
    step(3);
    check("rst_col_n", 32'(col_n), 32'h0000000E);
    check("rst_key", 32'(key), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);

    // Idle scan: column advances every 4 cycles, period 16
    @(negedge clk);
    greset_n = 1'b1;
    p0 = pulses;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      exp_cn = ~(4'b0001 << ((k / 4) % 4));
      check("idle_col_n", 32'(col_n), 32'(exp_cn));
    end
    check("idle_no_valid", 32'(pulses - p0), 32'h0);

    // Table: single presses across the key map
    for (int v = 0; v < 6; v++) begin
      p0 = pulses;
      pressed = vecs[v].mask;
      step(50);
      check("vec_key", 32'(key), 32'(vecs[v].exp_key));
      check("vec_one_pulse", 32'(pulses - p0), 32'h1);
      check("vec_held", 32'(key_held), 32'h1);
      pressed = 16'h0;
      step(20);
      check("vec_released", 32'(key_held), 32'h0);
      check("vec_no_repulse", 32'(pulses - p0), 32'h1);
    end

    // r1 c2 held 50 cycles; exact release timing and scan resumption at c3
    p0 = pulses;
    pressed = 16'h0040;
    step(50);
    check("r1c2_key", 32'(key), 32'h6);
    check("r1c2_one_pulse", 32'(pulses - p0), 32'h1);
    pressed = 16'h0;
    step(10);
    check("r1c2_held_before", 32'(key_held), 32'h1);
    step(1);
    check("r1c2_held_fall", 32'(key_held), 32'h0);
    check("r1c2_col_c3", 32'(col_n), 32'h7);
    step(3);
    check("r1c2_c3_settle", 32'(col_n), 32'h7);
    step(1);
    check("r1c2_wrap_c0", 32'(col_n), 32'hE);

    // r3 c1 with onset bounce: low 3, high 2, low steady
    wait_col(4'b1101);
    p0 = pulses;
    c0 = cyc;
    pressed = 16'h2000;
    step(3);
    pressed = 16'h0;
    step(2);
    pressed = 16'h2000;
    step(30);
    check("bounce_one_pulse", 32'(pulses - p0), 32'h1);
    check("bounce_latency", 32'(last_pulse - c0), 32'd18);
    check("bounce_key", 32'(key), 32'hF);
    pressed = 16'h0;
    step(20);
    check("bounce_released", 32'(key_held), 32'h0);

    // r0 c3 and r2 c3 together: lowest row wins; releasing r0 gives no strobe
    p0 = pulses;
    pressed = 16'h0808;
    step(50);
    check("multi_key", 32'(key), 32'hA);
    check("multi_one_pulse", 32'(pulses - p0), 32'h1);
    p1 = pulses;
    pressed = 16'h0800;
    step(20);
    check("multi_no_new_pulse", 32'(pulses - p1), 32'h0);
    check("multi_key_kept", 32'(key), 32'hA);
    check("multi_held_clear", 32'(key_held), 32'h0);
    pressed = 16'h0;
    step(40);

    // Hold r2 c0, then press r0 c1: second key waits for the first release
    p0 = pulses;
    pressed = 16'h0100;
    step(50);
    check("hold_first_key", 32'(key), 32'h7);
    check("hold_first_pulse", 32'(pulses - p0), 32'h1);
    p1 = pulses;
    pressed = 16'h0102;
    step(60);
    check("hold_blocked", 32'(pulses - p1), 32'h0);
    check("hold_still_held", 32'(key_held), 32'h1);
    p1 = pulses;
    pressed = 16'h0002;
    step(60);
    check("hold_second_pulse", 32'(pulses - p1), 32'h1);
    check("hold_second_key", 32'(key), 32'h2);
    pressed = 16'h0;
    step(20);

    // Reset during PRESS_DB on r1 c1
    wait_col(4'b1101);
    p0 = pulses;
    pressed = 16'h0020;
    step(6);
    greset_n = 1'b0;
    #1;
    check("abort_col_n", 32'(col_n), 32'hE);
    check("abort_key", 32'(key), 32'h0);
    check("abort_valid", 32'(key_valid), 32'h0);
    check("abort_held", 32'(key_held), 32'h0);
    step(10);
    pressed = 16'h0;
    @(negedge clk);
    greset_n = 1'b1;
    step(3);
    check("abort_resume_c0", 32'(col_n), 32'hE);
    step(1);
    check("abort_resume_c1", 32'(col_n), 32'hD);
    step(20);
    check("abort_no_pulse", 32'(pulses - p0), 32'h0);
    pressed = 16'h0001;
    step(50);
    check("abort_after_key", 32'(key), 32'h1);
    check("abort_after_pulse", 32'(pulses - p0), 32'h1);
    pressed = 16'h0;
    step(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
